// File: rtl/usb_pkg.sv
// Shared encodings for the full-speed USB receive path.
package usb_pkg;

    typedef enum logic [2:0] {
        st_idle = 3'd0,
        st_sync = 3'd1,
        st_data = 3'd2,
        st_eop  = 3'd3,
        st_err  = 3'd4
    } rx_state_e;

    typedef enum logic [1:0] {
        LS_SE0 = 2'b00,
        LS_J   = 2'b01,
        LS_K   = 2'b10
    } line_state_e;

    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;
    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam int unsigned STUFF_LIMIT    = 6;

    // SE0 dominates; otherwise the differential receiver picks J or K.
    function automatic line_state_e decode_line(input logic j, input logic se0);
        if (se0)    return LS_SE0;
        else if (j) return LS_J;
        else        return LS_K;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/usb_crc16.sv
// Serial USB CRC16 (x^16+x^15+x^2+1), MSB-first register, preset to all ones.
// valid flags the fixed residual left after a correct CRC field has been shifted in.
module usb_crc16
    import usb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clken,
    input  logic dump,
    input  logic din,
    output logic valid
);

    logic [15:0] crc_q, crc_d;

    // One bit per clken: feedback shift, or plain drain when dumping the register.
    always_comb begin
        crc_d = crc_q;
        if (clken) begin
            if (dump) crc_d = {crc_q[14:0], 1'b1};
            else      crc_d = {crc_q[14:0], 1'b0} ^ ((din ^ crc_q[15]) ? CRC16_POLY : '0);
        end
    end

    // CRC register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) crc_q <= '1;
        else        crc_q <= crc_d;
    end

    assign valid = (crc_q == CRC16_RESIDUAL);

endmodule

// File: rtl/usb_rx.sv
// Full-speed USB receiver: synchronizer, 4x DPLL, SYNC detect, NRZI decode,
// destuffing, LSB-first byte assembly, EOP with CRC16 status.
// Optional build macro USB_RX_GLITCH_FILTER_EN: 3-sample majority filter on (j,se0).
module usb_rx
    import usb_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned SYNC_ZEROS  = 3
) (
    input  logic       clk_48,
    input  logic       rst_n,
    input  logic       rx_j,
    input  logic       rx_se0,
    input  logic       tx_en,
    output logic       rx_active,
    output logic [7:0] data,
    output logic       data_strobe,
    output logic       eop,
    output logic       crc16_ok,
    output logic       rx_err
);

    localparam logic [7:0] ZEROS_MIN = 8'(SYNC_ZEROS);

    logic [SYNC_STAGES-1:0] j_sync_q, j_sync_d, se0_sync_q, se0_sync_d;
    logic                   j_s, se0_s, j_f, se0_f;
    line_state_e            ls_cur, lvl_q, lvl_d, last_q, last_d;
    rx_state_e              state_q, state_d;
    logic [1:0]             phase_q, phase_d;
    logic [7:0]             zeros_q, zeros_d, shreg_q, shreg_d, data_q, data_d;
    logic [2:0]             ones_q, ones_d, bit_cnt_q, bit_cnt_d;
    logic                   partial_q, partial_d, se0_seen_q, se0_seen_d, armed_q, armed_d;
    logic                   strobe_q, strobe_d, eop_q, eop_d, ok_q, ok_d, err_q, err_d;
    logic                   sample, dec, crc_en, crc_valid, crc_rst_n;

    // Metastability chains on the raw comparator outputs.
    always_comb begin
        j_sync_d   = {j_sync_q[SYNC_STAGES-2:0], rx_j};
        se0_sync_d = {se0_sync_q[SYNC_STAGES-2:0], rx_se0};
    end

    assign j_s   = j_sync_q[SYNC_STAGES-1];
    assign se0_s = se0_sync_q[SYNC_STAGES-1];

`ifdef USB_RX_GLITCH_FILTER_EN
    logic [1:0] g0_q, g0_d, g1_q, g1_d;

    // History for the majority vote over the newest three synchronized samples.
    always_comb begin
        g0_d = {j_s, se0_s};
        g1_d = g0_q;
    end

    // Majority history registers.
    always_ff @(posedge clk_48 or negedge rst_n) begin
        if (!rst_n) begin
            g0_q <= 2'b10;
            g1_q <= 2'b10;
        end else begin
            g0_q <= g0_d;
            g1_q <= g1_d;
        end
    end

    assign j_f   = maj3(j_s, g0_q[1], g1_q[1]);
    assign se0_f = maj3(se0_s, g0_q[0], g1_q[0]);
`else
    assign j_f   = j_s;
    assign se0_f = se0_s;
`endif

    assign ls_cur    = decode_line(j_f, se0_f);
    assign sample    = (phase_q == 2'd2);
    assign dec       = (lvl_q == last_q);
    assign crc_rst_n = rst_n & (state_q != st_idle);

    // DPLL, NRZI decode, destuffing and packet state machine.
    always_comb begin
        lvl_d      = ls_cur;
        phase_d    = (ls_cur != lvl_q) ? 2'd0 : phase_q + 2'd1;
        armed_d    = armed_q;
        if (tx_en)              armed_d = 1'b0;
        else if (lvl_q == LS_J) armed_d = 1'b1;
        last_d     = sample ? lvl_q : last_q;
        state_d    = state_q;
        zeros_d    = zeros_q;
        ones_d     = ones_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        partial_d  = partial_q;
        se0_seen_d = se0_seen_q;
        data_d     = data_q;
        strobe_d   = 1'b0;
        eop_d      = 1'b0;
        ok_d       = 1'b0;
        err_d      = 1'b0;
        crc_en     = 1'b0;
        case (state_q)
            st_idle: begin
                last_d     = LS_J;
                zeros_d    = '0;
                ones_d     = '0;
                bit_cnt_d  = '0;
                partial_d  = 1'b0;
                se0_seen_d = 1'b0;
                if (!tx_en && armed_q && lvl_q == LS_K) state_d = st_sync;
            end
            st_sync: begin
                if (sample) begin
                    if (lvl_q == LS_SE0) state_d = st_idle;
                    else if (dec)        state_d = (zeros_q >= ZEROS_MIN) ? st_data : st_idle;
                    else if (zeros_q < ZEROS_MIN) zeros_d = zeros_q + 8'd1;
                end
            end
            st_data: begin
                if (sample) begin
                    if (lvl_q == LS_SE0) begin
                        state_d   = st_eop;
                        partial_d = (bit_cnt_q != 3'd0);
                    end else if (ones_q == 3'(STUFF_LIMIT)) begin
                        ones_d = '0;
                        if (dec) begin
                            err_d   = 1'b1;
                            state_d = st_err;
                        end
                    end else begin
                        crc_en    = 1'b1;
                        shreg_d   = {dec, shreg_q[7:1]};
                        ones_d    = dec ? ones_q + 3'd1 : 3'd0;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            data_d   = {dec, shreg_q[7:1]};
                            strobe_d = 1'b1;
                        end
                    end
                end
            end
            st_eop: begin
                if (sample && lvl_q == LS_J) begin
                    state_d = st_idle;
                    if (partial_q) err_d = 1'b1;
                    else begin
                        eop_d = 1'b1;
                        ok_d  = crc_valid;
                    end
                end
            end
            st_err: begin
                if (sample) begin
                    if (lvl_q == LS_SE0)                 se0_seen_d = 1'b1;
                    else if (lvl_q == LS_J && se0_seen_q) state_d   = st_idle;
                end
            end
            default: state_d = st_idle;
        endcase
        // Local transmit owns the bus: drop whatever was in flight without reporting it.
        if (tx_en) begin
            state_d  = st_idle;
            strobe_d = 1'b0;
            eop_d    = 1'b0;
            ok_d     = 1'b0;
            err_d    = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_48 or negedge rst_n) begin
        if (!rst_n) begin
            j_sync_q   <= '1;
            se0_sync_q <= '0;
            lvl_q      <= LS_J;
            last_q     <= LS_J;
            state_q    <= st_idle;
            phase_q    <= '0;
            zeros_q    <= '0;
            ones_q     <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            data_q     <= '0;
            partial_q  <= 1'b0;
            se0_seen_q <= 1'b0;
            armed_q    <= 1'b1;
            strobe_q   <= 1'b0;
            eop_q      <= 1'b0;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            j_sync_q   <= j_sync_d;
            se0_sync_q <= se0_sync_d;
            lvl_q      <= lvl_d;
            last_q     <= last_d;
            state_q    <= state_d;
            phase_q    <= phase_d;
            zeros_q    <= zeros_d;
            ones_q     <= ones_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            data_q     <= data_d;
            partial_q  <= partial_d;
            se0_seen_q <= se0_seen_d;
            armed_q    <= armed_d;
            strobe_q   <= strobe_d;
            eop_q      <= eop_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
        end
    end

    usb_crc16 u_crc16 (
        .clk   (clk_48),
        .rst_n (crc_rst_n),
        .clken (crc_en),
        .dump  (1'b0),
        .din   (dec),
        .valid (crc_valid)
    );

    assign rx_active   = (state_q == st_data) || (state_q == st_eop) || (state_q == st_err);
    assign data        = data_q;
    assign data_strobe = strobe_q;
    assign eop         = eop_q;
    assign crc16_ok    = ok_q;
    assign rx_err      = err_q;

endmodule

// File: tb/tb_usb_rx.sv
// Bench for usb_rx: packets are built from byte lists (bit stuffing, NRZI, SYNC,
// EOP) and the observed byte stream / pulses are compared with a packet-level model.
module tb_usb_rx;

    typedef byte unsigned byte_q_t[$];
    typedef bit           bit_q_t[$];
    typedef int           lvl_q_t[$];

    localparam int L_SE0 = 0;
    localparam int L_J   = 1;
    localparam int L_K   = 2;

    logic       clk_48 = 1'b0;
    logic       rst_n, rx_j, rx_se0, tx_en;
    logic       rx_active, data_strobe, eop, crc16_ok, rx_err;
    logic [7:0] data;

    int n_checks = 0;
    int n_errors = 0;

    byte unsigned got[$];
    int           n_eop = 0, n_err = 0, n_inact = 0;
    bit           last_ok = 1'b0;

    usb_rx #(.SYNC_STAGES(2), .SYNC_ZEROS(3)) dut (
        .clk_48      (clk_48),
        .rst_n       (rst_n),
        .rx_j        (rx_j),
        .rx_se0      (rx_se0),
        .tx_en       (tx_en),
        .rx_active   (rx_active),
        .data        (data),
        .data_strobe (data_strobe),
        .eop         (eop),
        .crc16_ok    (crc16_ok),
        .rx_err      (rx_err)
    );

    always #5 clk_48 = ~clk_48;

    // Output monitor on the falling edge.
    always @(negedge clk_48) begin
        if (rst_n) begin
            if (data_strobe) begin
                got.push_back(data);
                if (!rx_active) n_inact++;
            end
            if (eop) begin
                n_eop++;
                last_ok = crc16_ok;
            end
            if (rx_err) n_err++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reflected (LSB-first) CRC-16/USB over whole bytes.
    function automatic logic [15:0] crc_refl(input byte_q_t b);
        logic [15:0] c = 16'hFFFF;
        foreach (b[i]) begin
            c = c ^ {8'h00, b[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    // A correct CRC field leaves the reflected register at 0xB001.
    function automatic bit crc_good(input byte_q_t b);
        return crc_refl(b) == 16'hB001;
    endfunction

    function automatic bit_q_t stuff_bits(input byte_q_t b, input bit_q_t tail);
        bit_q_t raw, out;
        int     ones = 0;
        foreach (b[i]) for (int k = 0; k < 8; k++) raw.push_back(b[i][k]);
        foreach (tail[i]) raw.push_back(tail[i]);
        foreach (raw[i]) begin
            out.push_back(raw[i]);
            ones = raw[i] ? ones + 1 : 0;
            if (ones == 6) begin
                out.push_back(1'b0);
                ones = 0;
            end
        end
        return out;
    endfunction

    // SYNC pattern followed by NRZI line levels: 0 toggles, 1 holds.
    function automatic lvl_q_t nrzi_levels(input bit_q_t bits);
        lvl_q_t lv;
        int     cur = L_K;
        lv = {L_K, L_J, L_K, L_J, L_K, L_J, L_K, L_K};
        foreach (bits[i]) begin
            if (!bits[i]) cur = (cur == L_K) ? L_J : L_K;
            lv.push_back(cur);
        end
        return lv;
    endfunction

    task automatic set_line(input int l);
        rx_se0 = (l == L_SE0);
        rx_j   = (l == L_J);
    endtask

    task automatic idle(input int n);
        set_line(L_J);
        repeat (n) @(negedge clk_48);
    endtask

    // Each level held 4 clocks, or alternately 5/3 clocks when jittered.
    task automatic drive(input lvl_q_t lv, input bit jit);
        bit ph = 1'($urandom_range(0, 1));
        foreach (lv[i]) begin
            set_line(lv[i]);
            repeat (jit ? (ph ? 5 : 3) : 4) @(negedge clk_48);
            ph = ~ph;
        end
    endtask

    task automatic run_packet(input string tag, input byte_q_t b, input bit_q_t tail, input bit jit);
        lvl_q_t lv;
        int     s_got = got.size(), s_eop = n_eop, s_err = n_err, s_in = n_inact;
        bit     partial = (tail.size() % 8) != 0;
        lv = nrzi_levels(stuff_bits(b, tail));
        lv.push_back(L_SE0);
        lv.push_back(L_SE0);
        lv.push_back(L_J);
        drive(lv, jit);
        idle(16);
        check({tag, "_nbytes"}, got.size() - s_got, b.size());
        for (int i = 0; i < b.size() && s_got + i < got.size(); i++)
            check({tag, "_byte"}, got[s_got + i], b[i]);
        check({tag, "_eop"}, n_eop - s_eop, partial ? 0 : 1);
        check({tag, "_err"}, n_err - s_err, partial ? 1 : 0);
        check({tag, "_strobe_inactive"}, n_inact - s_in, 0);
        check({tag, "_active_after"}, rx_active, 0);
        if (!partial) check({tag, "_crc_ok"}, last_ok, crc_good(b));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        byte_q_t     b;
        bit_q_t      tail, bits;
        lvl_q_t      lv;
        logic [15:0] c;
        int          s_got, s_eop, s_err;

        rst_n = 1'b0; tx_en = 1'b0;
        set_line(L_J);
        repeat (3) @(negedge clk_48);
        #1 check("reset_outputs", {rx_active, data, data_strobe, eop, crc16_ok, rx_err}, 0);
        @(negedge clk_48);
        rst_n = 1'b1;
        idle(8);
        check("post_reset_active", rx_active, 0);

        // Basic byte, then a run of ones requiring a stuff bit.
        b = {8'hA5}; tail = {};
        run_packet("a5", b, tail, 1'b0);
        b = {8'hFF, 8'h00};
        run_packet("ff00", b, tail, 1'b0);

        // Seven non-transitions after SYNC: stuff violation.
        bits = {};
        for (int i = 0; i < 7; i++) bits.push_back(1'b1);
        for (int i = 0; i < 4; i++) bits.push_back(1'($urandom_range(0, 1)));
        s_got = got.size(); s_eop = n_eop; s_err = n_err;
        drive(nrzi_levels(bits), 1'b0);
        repeat (3) @(negedge clk_48);
        check("stufferr_active_held", rx_active, 1);
        lv = {L_SE0, L_SE0, L_J};
        drive(lv, 1'b0);
        idle(16);
        check("stufferr_err", n_err - s_err, 1);
        check("stufferr_nbytes", got.size() - s_got, 0);
        check("stufferr_eop", n_eop - s_eop, 0);
        check("stufferr_active_after", rx_active, 0);

        // DATA0 with a CRC field covering every byte fed to the checker.
        b = {8'hC3, 8'h01, 8'h02};
        c = ~crc_refl(b);
        b.push_back(c[7:0]);
        b.push_back(c[15:8]);
        run_packet("data0_good", b, tail, 1'b0);
        check("data0_good_ok_is_1", last_ok, 1);
        b[1] = b[1] ^ 8'h04;
        run_packet("data0_bad", b, tail, 1'b0);
        check("data0_bad_ok_is_0", last_ok, 0);

        // Jittered bit periods; truncated byte.
        b = {8'hA5};
        run_packet("a5_jitter", b, tail, 1'b1);
        for (int i = 0; i < 5; i++) tail.push_back(1'($urandom_range(0, 1)));
        run_packet("partial5", b, tail, 1'b0);

        // Local transmit takes the bus mid-packet.
        b = {8'h3C}; tail = {1'b0, 1'b1, 1'b0};
        s_got = got.size(); s_eop = n_eop; s_err = n_err;
        drive(nrzi_levels(stuff_bits(b, tail)), 1'b0);
        repeat (2) @(negedge clk_48);
        check("txen_active_before", rx_active, 1);
        tx_en = 1'b1;
        @(negedge clk_48);
        check("txen_active_next", rx_active, 0);
        for (int i = 0; i < 20; i++) begin
            set_line(($urandom_range(0, 1) != 0) ? L_K : L_J);
            repeat (4) @(negedge clk_48);
        end
        idle(8);
        tx_en = 1'b0;
        idle(16);
        check("txen_nbytes", got.size() - s_got, 1);
        if (got.size() > s_got) check("txen_byte", got[s_got], 8'h3C);
        check("txen_eop", n_eop - s_eop, 0);
        check("txen_err", n_err - s_err, 0);
        b = {8'h81}; tail = {};
        run_packet("after_txen", b, tail, 1'b0);

        // Asynchronous reset in the middle of the second byte.
        b = {8'h5A, 8'h96};
        lv = nrzi_levels(stuff_bits(b, tail));
        repeat (4) void'(lv.pop_back());
        drive(lv, 1'b0);
        check("rst_pre_data", data, 8'h5A);
        check("rst_pre_active", rx_active, 1);
        rst_n = 1'b0;
        #1 check("rst_mid_outputs", {rx_active, data, data_strobe, eop, crc16_ok, rx_err}, 0);
        repeat (3) @(negedge clk_48);
        rst_n = 1'b1;
        idle(16);
        check("rst_after_active", rx_active, 0);
        b = {8'hA5};
        run_packet("after_rst", b, tail, 1'b1);

        // Randomized packets: lengths, contents, CRC fields, truncation and jitter.
        for (int n = 0; n < 40; n++) begin
            b = {}; tail = {};
            for (int i = 0; i < $urandom_range(1, 5); i++) b.push_back(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 1) != 0) begin
                c = ~crc_refl(b);
                b.push_back(c[7:0]);
                b.push_back(c[15:8]);
                if ($urandom_range(0, 3) == 0) b[0] = b[0] ^ 8'(1 << $urandom_range(0, 7));
            end
            if ($urandom_range(0, 9) < 3)
                for (int i = 0; i < $urandom_range(1, 7); i++) tail.push_back(1'($urandom_range(0, 1)));
            run_packet("rand", b, tail, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
